// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the packed
// Z/C/V/S status layout used by the controller's register interface.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Bit positions of each flag inside the 4-bit status word.
  localparam int FLAG_S  = 0;
  localparam int FLAG_V  = 1;
  localparam int FLAG_C  = 2;
  localparam int FLAG_Z  = 3;
  localparam int NFLAGS  = 4;

  // Field order matches the FLAG_* indices when viewed as logic [3:0].
  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic s;
  } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done handshake plus operand, result and flag bus of seq_alu.
interface seq_alu_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [1:0]         sel;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               Z, C, V, S;

  modport master (output A, B, sel, start,
                  input  busy, done, result, Z, C, V, S);
  modport slave  (input  A, B, sel, start,
                  output busy, done, result, Z, C, V, S);
endinterface

// File: rtl/seq_mul_core.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps.
// acc_nxt exposes the sum including the current step so the final product is
// available on the same edge that retires the last step.
module seq_mul_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_sh, acc;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt;

  assign acc_nxt = b_sh[0] ? acc + a_sh : acc;
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Clocked ALU: single-cycle SUB/AND/XOR, WIDTH-cycle MUL, registered result
// and flags that only change on a completion (signalled by a one-cycle done).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  state_e             state;
  op_e                op;
  logic [2*WIDTH-1:0] res, sc_res, acc_nxt;
  logic [WIDTH-1:0]   diff;
  flags_t             flg, sc_flg, mul_flg;
  logic [NFLAGS-1:0]  flg_w;
  logic               load, step, last;

  assign op   = op_e'(bus.sel);
  assign load = bus.start && (state == IDLE) && (op == OP_MUL);
  assign step = (state == MUL);

  seq_mul_core #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (bus.A),
    .b       (bus.B),
    .acc_nxt (acc_nxt),
    .last    (last)
  );

  always_comb begin
    diff   = bus.A - bus.B;
    sc_res = '0;
    sc_flg = '0;
    case (op)
      OP_SUB: begin
        sc_res   = {{WIDTH{diff[WIDTH-1]}}, diff};
        sc_flg.c = (bus.A < bus.B);
        // Signed overflow: operands of opposite sign and result sign differs from A.
        sc_flg.v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
        sc_flg.s = diff[WIDTH-1];
      end
      OP_AND: begin
        sc_res   = {{WIDTH{1'b0}}, bus.A & bus.B};
        sc_flg.s = sc_res[WIDTH-1];
      end
      OP_XOR: begin
        sc_res   = {{WIDTH{1'b0}}, bus.A ^ bus.B};
        sc_flg.s = sc_res[WIDTH-1];
      end
      default: ;
    endcase
    sc_flg.z = (sc_res == '0);

    mul_flg   = '0;
    mul_flg.z = (acc_nxt == '0);
    mul_flg.s = acc_nxt[2*WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.done <= 1'b0;
      res      <= '0;
      flg      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (op == OP_MUL) begin
            state <= MUL;
          end else begin
            res      <= sc_res;
            flg      <= sc_flg;
            bus.done <= 1'b1;
          end
        end
        MUL: if (last) begin
          res      <= acc_nxt;
          flg      <= mul_flg;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flg_w      = flg;
  assign bus.busy   = (state == MUL);
  assign bus.result = res;
  assign bus.Z      = flg_w[FLAG_Z];
  assign bus.C      = flg_w[FLAG_C];
  assign bus.V      = flg_w[FLAG_V];
  assign bus.S      = flg_w[FLAG_S];
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed scenarios then random traffic, with
// expected results computed from plain integer arithmetic at issue time.
module tb_seq_alu;
  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    logic [3:0]     flg;   // {Z,C,V,S}
    int             edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  exp_t q[$];
  int   edge_n  = 0;
  int   mul_acc = -100;
  int   checks  = 0;
  int   passes  = 0;

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   m, r, d, sa, sb, t;
    logic z, c, v, s;
    m = 1 << W;
    c = 0; v = 0; s = 0; r = 0;
    case (op)
      0: begin r = a * b; s = ((r >> (2*W-1)) & 1) != 0; end
      1: begin
        d  = (a - b + m) % m;
        sa = (a >= m/2) ? a - m : a;
        sb = (b >= m/2) ? b - m : b;
        t  = sa - sb;
        c  = (a < b);
        v  = (t < -(m/2)) || (t > m/2 - 1);
        s  = (d >= m/2);
        r  = s ? d + (m*m - m) : d;
      end
      2: begin r = a & b; s = ((r >> (W-1)) & 1) != 0; end
      default: begin r = a ^ b; s = ((r >> (W-1)) & 1) != 0; end
    endcase
    z = (r == 0);
    e.res = r[2*W-1:0];
    e.flg = {z, c, v, s};
    e.edge_n = 0;
    return e;
  endfunction

  // Present a start for the next edge; the model decides whether it is accepted.
  task automatic issue(input int op, input int a, input int b);
    exp_t e;
    int   nxt;
    bus.A = a[W-1:0]; bus.B = b[W-1:0]; bus.sel = op[1:0]; bus.start = 1'b1;
    nxt = edge_n + 1;
    if (nxt > mul_acc + W) begin
      e = model(op, a, b);
      if (op == 0) begin
        mul_acc  = nxt;
        e.edge_n = nxt + W;
      end else begin
        e.edge_n = nxt;
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    mul_acc = -100;
    idle(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_result", 32'(bus.result), 0);
      chk("rst_ctl", {bus.busy, bus.done, bus.Z, bus.C, bus.V, bus.S}, 0);
    end else begin
      chk("busy", 32'(bus.busy), 32'((edge_n >= mul_acc) && (edge_n < mul_acc + W)));
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", 32'(bus.result), 32'(e.res));
          chk("flags", {bus.Z, bus.C, bus.V, bus.S}, 32'(e.flg));
          chk("done_edge", edge_n, e.edge_n);
        end
      end
      if (q.size() != 0 && q[0].edge_n < edge_n) begin
        chk("missing_done", edge_n, q[0].edge_n);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.A = '0; bus.B = '0; bus.sel = '0; bus.start = 1'b0;
    #1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    issue(0, 15, 3);  idle(W + 1);          // 8'h2D
    issue(1, 10, 3);  idle(1);
    issue(1, 3, 3);   idle(1);
    issue(2, 12, 2);  idle(1);
    issue(3, 12, 2);  idle(1);
    issue(1, 3, 5);   idle(1);              // 8'hFE, C=1
    issue(1, 8, 1);   idle(1);              // V=1
    issue(0, 7, 2);   issue(1, 1, 1);       // SUB ignored while busy
    idle(W + 1);
    issue(3, 9, 6);   issue(2, 13, 7);  issue(1, 2, 9);
    idle(1);
    issue(0, 5, 11);  idle(W - 1);
    issue(3, 1, 2);                          // lands in last busy cycle: ignored
    issue(2, 15, 6);                         // lands in done cycle: accepted
    idle(2);

    issue(0, 15, 15); idle(1);
    do_reset();
    idle(1);
    issue(0, 15, 15); idle(W + 1);          // 8'hE1, S=1

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        issue($urandom_range(0, 3), $urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1));
      else
        idle(1);
    end
    idle(W + 3);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
